// File: rtl/pipelined_subtractor_pkg.sv
// Shared sizing helpers for the pipelined ripple-borrow subtractor.
// Slice width and the configuration legality check live here.
package pipelined_subtractor_pkg;

  localparam int WIDTH_DEF  = 16;
  localparam int STAGES_DEF = 4;
  localparam int SLICE      = WIDTH_DEF / STAGES_DEF;

  function automatic int slice_w(int w, int s);
    return (s >= 1) ? w / s : 1;
  endfunction

  function automatic bit cfg_ok(int w, int s);
    return (s >= 1) && (w % s == 0);
  endfunction

endpackage

// File: rtl/pipelined_subtractor_fs.sv
// One-bit full subtractor: diff = x - y - bIn with borrow-out.
// Chained per slice to form the ripple-borrow path of each stage.
module full_subtractor
  import pipelined_subtractor_pkg::*;
(
  input  logic x,
  input  logic y,
  input  logic bIn,
  output logic diff,
  output logic bOut
);

  assign diff = x ^ y ^ bIn;
  assign bOut = (~x & y) | (~x & bIn) | (y & bIn);

endmodule

// File: rtl/pipelined_subtractor.sv
// Pipelined N-bit ripple-borrow subtractor, one slice per stage.
// Upper operand slices ride along (skew); low results ride out (deskew).
module pipelined_subtractor
  import pipelined_subtractor_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int STAGES = STAGES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int SL = slice_w(WIDTH, STAGES);

  if (!cfg_ok(WIDTH, STAGES)) begin : g_bad_cfg
    $error("pipelined_subtractor: WIDTH must be a multiple of STAGES >= 1");
  end

  logic adv;

  assign adv      = ~(out_valid & ~out_ready);
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int LO = k * SL;
    localparam int HI = LO + SL;

    logic [WIDTH-LO-1:0] xa;
    logic [WIDTH-LO-1:0] xb;
    logic                brin;
    logic                vin;
    logic [SL-1:0]       sd;
    logic [SL:0]         bc;
    logic [HI-1:0]       d_d;
    logic [HI-1:0]       d_q;
    logic                br_d;
    logic                br_q;
    logic                v_d;
    logic                v_q;

    if (k == 0) begin : g_src
      assign xa   = a;
      assign xb   = b;
      assign brin = bin;
      assign vin  = in_valid;
      always_comb d_d = sd;
    end else begin : g_src
      assign xa   = g_st[k-1].g_op.a_q;
      assign xb   = g_st[k-1].g_op.b_q;
      assign brin = g_st[k-1].br_q;
      assign vin  = g_st[k-1].v_q;
      always_comb d_d = {sd, g_st[k-1].d_q};
    end

    assign bc[0] = brin;

    for (genvar j = 0; j < SL; j++) begin : g_bit
      full_subtractor u_fs (
        .x    (xa[j]),
        .y    (xb[j]),
        .bIn  (bc[j]),
        .diff (sd[j]),
        .bOut (bc[j+1])
      );
    end

    always_comb begin
      br_d = bc[SL];
      v_d  = vin;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        d_q  <= '0;
        br_q <= 1'b0;
        v_q  <= 1'b0;
      end else if (adv) begin
        d_q  <= d_d;
        br_q <= br_d;
        v_q  <= v_d;
      end
    end

    if (k < STAGES - 1) begin : g_op
      localparam int OW = WIDTH - HI;
      logic [OW-1:0] a_d;
      logic [OW-1:0] a_q;
      logic [OW-1:0] b_d;
      logic [OW-1:0] b_q;

      always_comb begin
        a_d = xa[WIDTH-LO-1:SL];
        b_d = xb[WIDTH-LO-1:SL];
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end else begin : g_ov
      logic ovf_d;
      logic ovf_q;

      // Last slice holds the operand sign bits and the result sign bit.
      always_comb ovf_d = (xa[SL-1] ^ xb[SL-1]) & (sd[SL-1] ^ xa[SL-1]);

      always_ff @(posedge clk) begin
        if (rst) ovf_q <= 1'b0;
        else if (adv) ovf_q <= ovf_d;
      end
    end
  end

  assign out_valid = g_st[STAGES-1].v_q;
  assign diff      = g_st[STAGES-1].d_q;
  assign bout      = g_st[STAGES-1].br_q;
  assign ovf       = g_st[STAGES-1].g_ov.ovf_q;

endmodule

// File: doc/pipelined_subtractor.md
Name: pipelined_subtractor

Overview:
- Pipelined N-bit ripple-borrow subtractor computing A - B - bin; the inverse-direction companion of the pipelined adder datapath.
- Operands are split into STAGES equal slices; each pipeline stage resolves one slice with a chain of bit-level full subtractors and registers its borrow for the next stage.
- Input skew and output deskew registers keep slices aligned. A valid/ready handshake on both sides allows back-pressure.

Parameters:
WIDTH, 16, operand and difference width in bits; must be divisible by STAGES
STAGES, 4, number of pipeline stages; SLICE = WIDTH/STAGES bits per stage; STAGES >= 1

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
in_valid  input  1  operands present this cycle
in_ready  output  1  block accepts operands this cycle
a  input  WIDTH  minuend, unsigned or two's complement
b  input  WIDTH  subtrahend
bin  input  1  borrow-in, subtracted at bit 0
out_valid  output  1  result present
out_ready  input  1  downstream accepts result
diff  output  WIDTH  a - b - bin, modulo 2^WIDTH
bout  output  1  borrow-out; 1 iff unsigned a < b + bin
ovf  output  1  signed overflow; 1 iff sign(a) != sign(b) and sign(diff) != sign(a)

Behaviour:
- Reset: one clock, reset is synchronous and active-high; ports are clk and rst. On rst=1 at a rising edge:
  - All stage valid bits, skew, deskew and borrow registers clear to 0.
  - Outputs after reset: out_valid=0, diff=0, bout=0, ovf=0.
  - in_ready=1 in the cycle after reset.
- Advance and stall:
  - advance = ~(out_valid & ~out_ready).
  - in_ready = advance, combinational from out_valid/out_ready; it has no dependency on in_valid.
  - On advance, every stage register loads from its predecessor. Stage 0 loads {a, b, bin, in_valid}.
  - When advance=0, all registers hold and outputs remain stable.
- Accept and bubbles:
  - An input is accepted when in_valid & in_ready.
  - in_valid=0 while advancing inserts a bubble: the valid bit is 0 and the data is don't-care. Data registers may still load.
- Stage k (0..STAGES-1):
  - Subtracts slice k of a and b with the borrow registered by stage k-1; stage 0 uses bin.
  - Produces SLICE difference bits and one registered borrow.
  - Slice k operands enter through k skew registers. Difference slice k leaves through STAGES-1-k deskew registers.
- Latency and throughput:
  - Exactly STAGES advancing cycles from accept to out_valid=1 for that operand set.
  - Throughput is one result per cycle when out_ready is held at 1.
  - Results are delivered in order; none are dropped or duplicated under any out_ready pattern.
- Result fields:
  - bout = final-stage borrow.
  - ovf is computed from the MSB of the a and b slices carried with the final stage and the MSB of diff.
- Simultaneous events:
  - Accept in the same cycle as an output handshake is legal and required to sustain full rate.
  - rst has priority over every handshake.
- Reset mid-operation: in-flight results are discarded and never presented; out_valid=0 from the next cycle.
- Boundary cases:
  - STAGES=1: a single registered stage with latency 1 and no skew or deskew.
  - STAGES=WIDTH: 1-bit slices.
  - Out-of-range diff wraps modulo 2^WIDTH.

Decomposition:
- Shared package holds the localparam SLICE = WIDTH/STAGES and an elaboration-time check that WIDTH % STAGES == 0 and STAGES >= 1.
- No typedefs are required.
- One natural sub-module, full_subtractor(x, y, bIn, diff, bOut):
  - diff = x^y^bIn
  - bOut = (~x&y) | (~x&bIn) | (y&bIn)
- Instantiated SLICE times per stage via generate.

Test Plan:
1. Defaults, out_ready=1: a=0x0005, b=0x0003, bin=0 -> after 4 cycles diff=0x0002, bout=0, ovf=0, out_valid pulses 1 cycle.
2. a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1, ovf=0. Then a=0x1234, b=0x1234, bin=1 -> diff=0xFFFF, bout=1, ovf=0.
3. a=0x8000, b=0x0001 -> diff=0x7FFF, bout=0, ovf=1. a=0x7FFF, b=0xFFFF -> diff=0x8000, bout=1, ovf=1. Both checks exercise borrow ripple across all 4 stages.
4. Back-to-back: 8 consecutive operand sets with in_valid=1 and out_ready=1 -> 8 consecutive out_valid cycles starting at cycle 4, in order, matching a reference model.
5. Back-pressure: hold out_ready=0 for 5 cycles while a result is valid.
   - in_ready=0 throughout; diff, bout and ovf stay stable.
   - On release, results resume in order with no loss.
   - Follow with random out_ready and in_valid over 1000 vectors, scoreboarded.
6. Reset mid-stream: assert rst for 1 cycle with 3 results in flight -> out_valid=0, diff=0, bout=0, ovf=0 next cycle. No stale result ever appears. The next accepted input emerges after exactly 4 cycles.
